seq_stream_checker: RTL and testbench
=====================================

Name: seq_stream_checker

Overview:
- Receive-side checker for the gated free-running counter stream produced by the `conds` counter source.
- Source behaviour:
  - Counter increments by 1 on every clock, wrapping mod 2^WIDTH.
  - Driven onto `data` only while `en`=1; `data` is 0 while `en`=0.
- The checker locks onto that sequence, tracks the expected value every cycle (so gaps in `en` are tolerated), counts good beats and mismatches, and reports lock status.
- Sits in the verification/monitor path beside the source; pure sink, no backpressure.

Parameters:
- WIDTH, 8, data and expected-value width.
- LOCK_COUNT, 4, consecutive matching beats required to enter LOCKED (≥2).
- ERR_LIMIT, 3, consecutive mismatching beats in LOCKED that drop lock to HUNT (≥1).
- CNT_W, 16, width of the beat and error counters.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state immediately.
- en  in  1  beat qualifier; `data` is sampled only when 1.
- data  in  WIDTH  stream value; ignored when en=0.
- clear  in  1  synchronous clear of counters and FSM; priority over en.
- locked  out  1  high while FSM is in LOCKED.
- error_pulse  out  1  one-cycle pulse per mismatching beat in LOCKED.
- beat_count  out  CNT_W  matching beats counted in LOCKED; saturating.
- err_count  out  CNT_W  mismatching beats counted in LOCKED; saturating.
- expected  out  WIDTH  current expected value, valid in SYNC/LOCKED.
- sticky_err  out  1  see Optional Feature.

Behaviour:
- Reset values: FSM=HUNT; locked=0, error_pulse=0, beat_count=0, err_count=0, expected=0, sticky_err=0. Internal good_run=0, bad_run=0.
- All outputs are registered. An effect caused by the beat sampled at edge N is visible after edge N.
- `expected` advances by 1 mod 2^WIDTH on every clock in SYNC and LOCKED, regardless of en. This mirrors the source counter, which free-runs.
- HUNT:
  - en=1: expected<=data+1, good_run<=1, go to SYNC.
  - en=0: hold.
- SYNC:
  - en=1 and data==expected: good_run++. When good_run reaches LOCK_COUNT, go to LOCKED and clear bad_run.
  - en=1 and data!=expected: resynchronise with expected<=data+1 and good_run<=1; stay in SYNC.
  - No counter updates and no error_pulse in SYNC.
- LOCKED:
  - en=1 and match: beat_count++ (saturating at 2^CNT_W-1), bad_run<=0.
  - en=1 and mismatch: err_count++ (saturating), error_pulse=1 for one cycle, bad_run++. expected keeps free-running; it is not reloaded.
  - When bad_run reaches ERR_LIMIT: go to HUNT, locked falls.
  - The beat that first reaches LOCK_COUNT in SYNC is not counted in beat_count.
- clear=1 (synchronous):
  - FSM<=HUNT; beat_count, err_count, good_run, bad_run, sticky_err <= 0.
  - The en/data of that cycle is ignored.
- Asynchronous reset mid-operation: every register returns to its reset value immediately, with no wait for clk.
- Wrap-around: 255→0 at WIDTH=8 is a legal match. Compare arithmetic is WIDTH-bit modulo.
- Consecutive-ness is defined on en=1 beats only. Idle cycles with en=0 neither break nor extend good_run or bad_run.

Optional Feature:
- Macro: SEQCHK_STICKY_ERR_EN.
- Defined: sticky_err is set on any cycle where error_pulse is asserted. It is cleared only by reset or clear, and survives loss of lock.
- Undefined: no sticky register is built and sticky_err is tied to 0.

Test Plan:
- Lock: reset, then en=1 with data 5,6,7,8 on consecutive cycles → locked=1 after the 4th beat, expected=9, beat_count=0, err_count=0.
- Gap tolerance: locked at expected=14, en=0 for 3 cycles (data=0), then en=1 data=17 → match, beat_count+1, no error_pulse.
- Wrap: locked, beats 254,255,0,1 → all match, beat_count+4, locked stays 1.
- Error and lock loss: locked, expected=0x30, data=0x40 → error_pulse for 1 cycle, err_count=1, still locked. Two further consecutive mismatching beats → err_count=3, locked=0, FSM in HUNT. With the macro defined, sticky_err=1 throughout.
- SYNC resync: HUNT, beats 5,6,20,21,22,23 → no lock after 6; after 20 the FSM resyncs; locked=1 after beat 23; err_count=0.
- Reset and clear: assert reset asynchronously mid-cycle while locked with beat_count=9 → all outputs 0 before the next edge. Separately, clear=1 together with en=1 → counters 0, FSM in HUNT, beat ignored.

Source files
------------

// File: rtl/seq_stream_checker_if.sv
// Stream bus carrying the gated counter beats into seq_stream_checker.
interface seq_stream_checker_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             en;
  logic [WIDTH-1:0] data;

  modport master (output en, output data);
  modport slave  (input  en, input  data);

endinterface

// File: rtl/seq_stream_checker.sv
// Receive-side checker for a gated free-running counter stream.
// Hunts for the sequence, locks after LOCK_COUNT consecutive matching beats,
// counts good/bad beats while locked and drops lock after ERR_LIMIT
// consecutive mismatches. Optional sticky error flag: SEQCHK_STICKY_ERR_EN.
module seq_stream_checker #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_stream_checker_if.slave  bus,
  input  logic                 clear,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [CNT_W-1:0]     beat_count,
  output logic [CNT_W-1:0]     err_count,
  output logic [WIDTH-1:0]     expected,
  output logic                 sticky_err
);

  localparam int unsigned GR_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned BR_W = $clog2(ERR_LIMIT + 1);
  localparam logic [GR_W-1:0] LockCnt = GR_W'(LOCK_COUNT);
  localparam logic [BR_W-1:0] ErrLim  = BR_W'(ERR_LIMIT);

  typedef enum logic [1:0] {StHunt, StSync, StLocked} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [GR_W-1:0]  good_run_q, good_run_d;
  logic [BR_W-1:0]  bad_run_q, bad_run_d;
  logic [CNT_W-1:0] beat_count_q, beat_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             error_pulse_q, error_pulse_d;
  logic             match;

  assign match = (bus.data == expected_q);

  // Next-state: FSM transitions, expected-value tracking and counters.
  always_comb begin
    state_d       = state_q;
    expected_d    = expected_q;
    good_run_d    = good_run_q;
    bad_run_d     = bad_run_q;
    beat_count_d  = beat_count_q;
    err_count_d   = err_count_q;
    error_pulse_d = 1'b0;

    if (clear) begin
      // Beat on this cycle is ignored; expected simply holds.
      state_d      = StHunt;
      good_run_d   = '0;
      bad_run_d    = '0;
      beat_count_d = '0;
      err_count_d  = '0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (bus.en) begin
            expected_d = bus.data + 1'b1;
            good_run_d = GR_W'(1);
            state_d    = StSync;
          end
        end
        StSync: begin
          // Source counter free-runs, so expected advances even on idle cycles.
          expected_d = expected_q + 1'b1;
          if (bus.en) begin
            if (match) begin
              good_run_d = good_run_q + 1'b1;
              if (good_run_q + 1'b1 == LockCnt) begin
                state_d   = StLocked;
                bad_run_d = '0;
              end
            end else begin
              expected_d = bus.data + 1'b1;
              good_run_d = GR_W'(1);
            end
          end
        end
        StLocked: begin
          expected_d = expected_q + 1'b1;
          if (bus.en) begin
            if (match) begin
              if (beat_count_q != '1) beat_count_d = beat_count_q + 1'b1;
              bad_run_d = '0;
            end else begin
              if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
              error_pulse_d = 1'b1;
              bad_run_d     = bad_run_q + 1'b1;
              if (bad_run_q + 1'b1 == ErrLim) state_d = StHunt;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StHunt;
      expected_q    <= '0;
      good_run_q    <= '0;
      bad_run_q     <= '0;
      beat_count_q  <= '0;
      err_count_q   <= '0;
      error_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      expected_q    <= expected_d;
      good_run_q    <= good_run_d;
      bad_run_q     <= bad_run_d;
      beat_count_q  <= beat_count_d;
      err_count_q   <= err_count_d;
      error_pulse_q <= error_pulse_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign error_pulse = error_pulse_q;
  assign beat_count  = beat_count_q;
  assign err_count   = err_count_q;
  assign expected    = expected_q;

`ifdef SEQCHK_STICKY_ERR_EN
  logic sticky_q, sticky_d;

  // Sticky flag sets alongside error_pulse and survives loss of lock.
  always_comb begin
    sticky_d = clear ? 1'b0 : (sticky_q | error_pulse_d);
  end

  // Sticky error register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky_err = sticky_q;
`else
  assign sticky_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed self-checking bench for seq_stream_checker.
module tb_seq_stream_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        locked;
  logic        error_pulse;
  logic [15:0] beat_count;
  logic [15:0] err_count;
  logic [7:0]  expected;
  logic        sticky_err;

  int vectors = 0;
  int errors  = 0;

`ifdef SEQCHK_STICKY_ERR_EN
  localparam logic StickyOn = 1'b1;
`else
  localparam logic StickyOn = 1'b0;
`endif

  seq_stream_checker_if #(.WIDTH(8)) bus ();

  seq_stream_checker #(
    .WIDTH(8), .LOCK_COUNT(4), .ERR_LIMIT(3), .CNT_W(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear       (clear),
    .locked      (locked),
    .error_pulse (error_pulse),
    .beat_count  (beat_count),
    .err_count   (err_count),
    .expected    (expected),
    .sticky_err  (sticky_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, return 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [7:0] d, input logic c = 1'b0);
    @(negedge clk);
    bus.en   = e;
    bus.data = d;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0);
  endtask

  initial begin
    reset    = 1'b1;
    clear    = 1'b0;
    bus.en   = 1'b0;
    bus.data = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_pulse", error_pulse, 0);
    check("rst_beat", beat_count, 0);
    check("rst_err", err_count, 0);
    check("rst_exp", expected, 0);
    check("rst_sticky", sticky_err, 0);

    // Lock on 5,6,7,8
    step(1, 8'd5); step(1, 8'd6); step(1, 8'd7);
    check("lock_early", locked, 0);
    step(1, 8'd8);
    check("lock_locked", locked, 1);
    check("lock_exp", expected, 9);
    check("lock_beat", beat_count, 0);
    check("lock_err", err_count, 0);

    // Gap tolerance
    for (int v = 9; v <= 13; v++) step(1, 8'(v));
    check("gap_pre_beat", beat_count, 5);
    check("gap_pre_exp", expected, 14);
    idle(3);
    check("gap_idle_exp", expected, 17);
    check("gap_idle_locked", locked, 1);
    step(1, 8'd17);
    check("gap_beat", beat_count, 6);
    check("gap_pulse", error_pulse, 0);

    // Wrap 254,255,0,1
    idle(236);
    check("wrap_pre_exp", expected, 254);
    step(1, 8'd254); step(1, 8'd255); step(1, 8'd0); step(1, 8'd1);
    check("wrap_beat", beat_count, 10);
    check("wrap_locked", locked, 1);
    check("wrap_exp", expected, 2);
    check("wrap_err", err_count, 0);

    // Errors and lock loss
    idle(46);
    check("err_pre_exp", expected, 8'h30);
    step(1, 8'h40);
    check("err1_pulse", error_pulse, 1);
    check("err1_count", err_count, 1);
    check("err1_locked", locked, 1);
    check("err1_sticky", sticky_err, StickyOn);
    check("err1_exp", expected, 8'h31);
    idle(1);
    check("err1_pulse_gone", error_pulse, 0);
    check("err1_sticky_hold", sticky_err, StickyOn);
    step(1, 8'd0);
    check("err2_count", err_count, 2);
    check("err2_locked", locked, 1);
    step(1, 8'd0);
    check("err3_count", err_count, 3);
    check("err3_locked", locked, 0);
    check("err3_pulse", error_pulse, 1);
    check("err3_sticky", sticky_err, StickyOn);
    check("err3_beat", beat_count, 10);
    idle(1);
    check("hunt_sticky", sticky_err, StickyOn);
    check("hunt_locked", locked, 0);

    // Clear with en=1: beat 99 must be ignored
    step(1, 8'd99, 1'b1);
    check("clr_beat", beat_count, 0);
    check("clr_err", err_count, 0);
    check("clr_locked", locked, 0);
    check("clr_sticky", sticky_err, 0);
    step(1, 8'd100); step(1, 8'd101); step(1, 8'd102);
    check("clr_ignored", locked, 0);
    step(1, 8'd103);
    check("clr_relock", locked, 1);

    // SYNC resync
    step(0, 8'd0, 1'b1);
    check("rs_clr_locked", locked, 0);
    step(1, 8'd5); step(1, 8'd6); step(1, 8'd20);
    check("rs_exp", expected, 21);
    step(1, 8'd21); step(1, 8'd22);
    check("rs_no_lock", locked, 0);
    step(1, 8'd23);
    check("rs_locked", locked, 1);
    check("rs_exp2", expected, 24);
    check("rs_err", err_count, 0);

    // Asynchronous reset mid-cycle
    for (int v = 24; v <= 32; v++) step(1, 8'(v));
    check("ar_pre_beat", beat_count, 9);
    #2 reset = 1'b1;
    #1;
    check("ar_locked", locked, 0);
    check("ar_beat", beat_count, 0);
    check("ar_err", err_count, 0);
    check("ar_exp", expected, 0);
    check("ar_pulse", error_pulse, 0);
    check("ar_sticky", sticky_err, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
